// File: rtl/led7seg_scan_reader_if.sv
// Bundles the observed display bus (SA/LED) with the recovered digit outputs.
// The slave modport is the reader itself; the master modport is the display side.
interface led7seg_scan_reader_if;
    logic [3:0]  SA;
    logic [7:0]  LED;
    logic [15:0] DIG;
    logic [3:0]  DP;
    logic [3:0]  DVALID;
    logic [3:0]  BAD;
    logic        FRAME;

    modport master (
        output SA,
        output LED,
        input  DIG,
        input  DP,
        input  DVALID,
        input  BAD,
        input  FRAME
    );

    modport slave (
        input  SA,
        input  LED,
        output DIG,
        output DP,
        output DVALID,
        output BAD,
        output FRAME
    );
endinterface

// File: rtl/led7seg_scan_reader.sv
// Watches a multiplexed 4-digit 7-segment bus, waits for each dwell to settle,
// decodes the segment pattern to a hex nibble per position and flags full frames.
module led7seg_scan_reader #(
    parameter int SETTLE        = 4,
    parameter bit SA_ACTIVE_LOW = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    led7seg_scan_reader_if.slave bus
);

    localparam logic [7:0] SETTLE_V  = 8'(SETTLE);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    logic [11:0] s_q, s_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] dig_q, dig_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  dvalid_q, dvalid_d;
    logic [3:0]  bad_q, bad_d;
    logic        frame_q, frame_d;

    logic [11:0] sample;
    logic [3:0]  sel;
    logic        oneHot;
    logic [1:0]  pos;
    logic [4:0]  decoded;
    logic [3:0]  seenNext;

    // Returns {recognised, nibble} for LED[6:0] = {g,f,e,d,c,b,a}.
    function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        sample  = {bus.SA, bus.LED};
        sel     = SA_ACTIVE_LOW ? ~s_q[11:8] : s_q[11:8];
        decoded = decodeSeg(s_q[6:0]);
        oneHot  = 1'b1;
        pos     = 2'd0;
        case (sel)
            4'b0001: pos = 2'd0;
            4'b0010: pos = 2'd1;
            4'b0100: pos = 2'd2;
            4'b1000: pos = 2'd3;
            default: oneHot = 1'b0;
        endcase
        seenNext = seen_q | (4'b0001 << pos);
    end

    // Stability counting and capture; a whole-{SA,LED} change opens a new dwell.
    always_comb begin
        s_d      = sample;
        cnt_d    = cnt_q;
        done_d   = done_q;
        seen_d   = seen_q;
        dig_d    = dig_q;
        dp_d     = dp_q;
        dvalid_d = dvalid_q;
        bad_d    = bad_q;
        frame_d  = 1'b0;

        if (sample != s_q) begin
            cnt_d  = 8'd0;
            done_d = 1'b0;
        end else begin
            if (cnt_q != SETTLE_V) begin
                cnt_d = cnt_q + 8'd1;
            end
            if (cnt_q == SETTLE_M1 && oneHot && !done_q) begin
                done_d        = 1'b1;
                dp_d[pos]     = s_q[7];
                dvalid_d[pos] = 1'b1;
                if (decoded[4]) begin
                    dig_d[{pos, 2'b00} +: 4] = decoded[3:0];
                    bad_d[pos]               = 1'b0;
                end else begin
                    bad_d[pos] = 1'b1;
                end
                if (seenNext == 4'b1111) begin
                    frame_d = 1'b1;
                    seen_d  = 4'b0000;
                end else begin
                    seen_d = seenNext;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            seen_q   <= '0;
            dig_q    <= '0;
            dp_q     <= '0;
            dvalid_q <= '0;
            bad_q    <= '0;
            frame_q  <= 1'b0;
        end else begin
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            seen_q   <= seen_d;
            dig_q    <= dig_d;
            dp_q     <= dp_d;
            dvalid_q <= dvalid_d;
            bad_q    <= bad_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.DIG    = dig_q;
    assign bus.DP     = dp_q;
    assign bus.DVALID = dvalid_q;
    assign bus.BAD    = bad_q;
    assign bus.FRAME  = frame_q;

endmodule

// File: tb/tb_led7seg_scan_reader.sv
// Directed bench for led7seg_scan_reader with SETTLE=4 and active-low digit select.
// Inputs change and outputs are sampled on the falling edge, away from capture edges.
module tb_led7seg_scan_reader;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;
    int   frameCount;

    led7seg_scan_reader_if bus ();

    led7seg_scan_reader #(
        .SETTLE        (4),
        .SA_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Each FRAME pulse lasts one cycle, so one falling-edge sample sees it once.
    always @(negedge CLK) begin
        if (bus.FRAME === 1'b1) frameCount++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] sa, input logic [7:0] led, input int n);
        bus.SA  = sa;
        bus.LED = led;
        tick(n);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] hexPat [16];
        hexPat = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                   8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        checks     = 0;
        errors     = 0;
        frameCount = 0;
        RST_N      = 1'b0;
        bus.SA     = 4'hF;
        bus.LED    = 8'h00;
        tick(2);

        $display("[TB] reset state");
        checkOutput("rst_dig", bus.DIG, 16'h0000);
        checkOutput("rst_dp", 16'(bus.DP), 16'h0);
        checkOutput("rst_dvalid", 16'(bus.DVALID), 16'h0);
        checkOutput("rst_bad", 16'(bus.BAD), 16'h0);
        checkOutput("rst_frame", 16'(bus.FRAME), 16'h0);

        $display("[TB] single capture on digit 0");
        RST_N = 1'b1;
        applyStimulus(4'b1110, 8'h06, 4);
        checkOutput("pre_cap_dvalid", 16'(bus.DVALID), 16'h0);
        checkOutput("pre_cap_dig", bus.DIG, 16'h0000);
        tick(1);
        checkOutput("cap_dig", bus.DIG, 16'h0001);
        checkOutput("cap_dvalid", 16'(bus.DVALID), 16'h1);
        checkOutput("cap_bad", 16'(bus.BAD), 16'h0);

        $display("[TB] full scan frame");
        applyStimulus(4'b1110, 8'h4F, 6);
        applyStimulus(4'b1101, 8'h5B, 6);
        applyStimulus(4'b1011, 8'h06, 6);
        checkOutput("scan_frame_early", 16'(frameCount), 16'd0);
        applyStimulus(4'b0111, 8'hBF, 5);
        checkOutput("scan_frame_pulse", 16'(bus.FRAME), 16'h1);
        checkOutput("scan_dig", bus.DIG, 16'h0123);
        checkOutput("scan_dp", 16'(bus.DP), 16'h8);
        checkOutput("scan_dvalid", 16'(bus.DVALID), 16'hF);
        tick(1);
        checkOutput("scan_frame_end", 16'(bus.FRAME), 16'h0);
        checkOutput("scan_frame_count", 16'(frameCount), 16'd1);

        $display("[TB] glitch before settling");
        applyStimulus(4'b1110, 8'h7F, 2);
        applyStimulus(4'b1110, 8'h6F, 4);
        checkOutput("glitch_pre", bus.DIG, 16'h0123);
        tick(1);
        checkOutput("glitch_cap", bus.DIG, 16'h0129);

        $display("[TB] invalid selects");
        applyStimulus(4'b1111, 8'h3F, 10);
        applyStimulus(4'b1100, 8'h3F, 10);
        checkOutput("inv_dig", bus.DIG, 16'h0129);
        checkOutput("inv_dvalid", 16'(bus.DVALID), 16'hF);
        checkOutput("inv_bad", 16'(bus.BAD), 16'h0);
        checkOutput("inv_frames", 16'(frameCount), 16'd1);
        applyStimulus(4'b1011, 8'h00, 6);
        checkOutput("blank_bad", 16'(bus.BAD), 16'h4);
        checkOutput("blank_dig", bus.DIG, 16'h0129);

        $display("[TB] hex sweep on digit 0");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'b1110, hexPat[i], 6);
            checkOutput($sformatf("sweep_dig_%0d", i), 16'(bus.DIG[3:0]), 16'(i));
            checkOutput($sformatf("sweep_bad_%0d", i), 16'(bus.BAD[0]), 16'h0);
        end
        applyStimulus(4'b1110, 8'h7E, 6);
        checkOutput("unk_bad", 16'(bus.BAD), 16'h5);
        checkOutput("unk_dig", bus.DIG, 16'h012F);
        checkOutput("sweep_frames", 16'(frameCount), 16'd1);

        $display("[TB] reset mid-dwell");
        applyStimulus(4'b1101, 8'h66, 3);
        RST_N = 1'b0;
        tick(1);
        checkOutput("mid_rst_dig", bus.DIG, 16'h0000);
        checkOutput("mid_rst_dvalid", 16'(bus.DVALID), 16'h0);
        checkOutput("mid_rst_bad", 16'(bus.BAD), 16'h0);
        checkOutput("mid_rst_dp", 16'(bus.DP), 16'h0);
        RST_N = 1'b1;
        tick(4);
        checkOutput("post_rst_pre", 16'(bus.DVALID), 16'h0);
        tick(1);
        checkOutput("post_rst_dvalid", 16'(bus.DVALID), 16'h2);
        checkOutput("post_rst_dig", bus.DIG, 16'h0040);
        tick(6);
        checkOutput("hold_one_capture", 16'(frameCount), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
